// File: rtl/ntcrack_host_sequencer_if.sv
// Host streams (hash words in, recovered passwords out) plus the byte-serial cracker link.
// The master modport is the sequencer side; slave is the controller/cracker side.
interface ntcrack_host_sequencer_if #(
    parameter int HASH_BYTES     = 16,
    parameter int PASSWORD_BYTES = 20
);
    logic [8*HASH_BYTES-1:0]     hash_in_data;
    logic                        hash_in_valid;
    logic                        hash_in_ready;
    logic [7:0]                  new_hash_byte;
    logic                        store_hash_byte;
    logic                        go;
    logic                        match_found;
    logic                        my_turn;
    logic [7:0]                  password_byte;
    logic [8*PASSWORD_BYTES-1:0] pw_data;
    logic                        pw_valid;
    logic                        pw_ready;

    modport master (
        input  hash_in_data, hash_in_valid, match_found, my_turn, password_byte, pw_ready,
        output hash_in_ready, new_hash_byte, store_hash_byte, go, pw_data, pw_valid
    );

    modport slave (
        output hash_in_data, hash_in_valid, match_found, my_turn, password_byte, pw_ready,
        input  hash_in_ready, new_hash_byte, store_hash_byte, go, pw_data, pw_valid
    );
endinterface

// File: rtl/ntcrack_host_sequencer.sv
// Host-side sequencer for the ntcrackfpga cracker: loads hashes, starts the search, reads passwords.
// Optional watchdog on every wait state is enabled by defining NTCRACK_HOST_TIMEOUT_EN.
module ntcrack_host_sequencer #(
    parameter int NUM_HASHES     = 2,
    parameter int HASH_BYTES     = 16,
    parameter int PASSWORD_BYTES = 20,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    ntcrack_host_sequencer_if.master        bus,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [7:0]                      hashes_loaded_o
);
    localparam int HW_W = 8 * HASH_BYTES;
    localparam int PW_W = 8 * PASSWORD_BYTES;
    localparam int BI_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
    localparam int PI_W = (PASSWORD_BYTES > 1) ? $clog2(PASSWORD_BYTES) : 1;
    localparam int SC_W = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_B_WAIT, S_B_SETUP, S_B_STROBE, S_B_REL,
        S_G_WAIT, S_G_STROBE, S_G_REL, S_R_WAIT,
        S_P_CAP, S_P_STROBE, S_P_REL, S_EMIT, S_DONE
    } state_t;

    state_t            state_q, state_d, state_nxt_s;
    logic [HW_W-1:0]   word_q, word_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [PI_W-1:0]   pw_idx_q, pw_idx_d;
    logic [SC_W-1:0]   strobe_cnt_q, strobe_cnt_d;
    logic [7:0]        loaded_q, loaded_d;
    logic [PW_W-1:0]   pw_sr_q, pw_sr_d;
    logic [7:0]        nhb_q, nhb_d;
    logic              store_q, store_d;
    logic              go_q, go_d;
    logic              pw_valid_q, pw_valid_d;
    logic              hin_ready_q, hin_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              strobe_last_s;
    logic              is_strobe_s;
    logic              timeout_s;

    assign strobe_last_s = (strobe_cnt_q == SC_W'(STROBE_CYCLES - 1));
    assign is_strobe_s   = (state_q == S_B_STROBE) || (state_q == S_G_STROBE) ||
                           (state_q == S_P_STROBE);

`ifdef NTCRACK_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              error_q, error_d;
    logic              is_wait_s;

    assign is_wait_s = (state_q == S_B_WAIT) || (state_q == S_G_WAIT) ||
                       (state_q == S_R_WAIT) || (state_q == S_P_CAP);
    // Progress on the final cycle beats the watchdog.
    assign timeout_s = is_wait_s && (state_nxt_s == state_q) &&
                       (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in one wait state; error is sticky until reset.
    always_comb begin
        wdog_d  = (is_wait_s && (state_nxt_s == state_q)) ? wdog_q + WD_W'(1) : WD_W'(0);
        error_d = error_q | timeout_s;
    end

    // Watchdog registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog_q  <= WD_W'(0);
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign timeout_s = 1'b0;
    assign error_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (loaded_q == 8'(NUM_HASHES))) begin
                    state_nxt_s = S_G_WAIT;
                end else if (bus.hash_in_valid && hin_ready_q) begin
                    state_nxt_s = S_B_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_B_WAIT:   state_nxt_s = bus.my_turn ? S_B_SETUP : S_B_WAIT;
            S_B_SETUP:  state_nxt_s = S_B_STROBE;
            S_B_STROBE: state_nxt_s = strobe_last_s ? S_B_REL : S_B_STROBE;
            S_B_REL:    state_nxt_s = (byte_idx_q == BI_W'(HASH_BYTES - 1)) ? S_IDLE : S_B_WAIT;
            S_G_WAIT:   state_nxt_s = bus.my_turn ? S_G_STROBE : S_G_WAIT;
            S_G_STROBE: state_nxt_s = strobe_last_s ? S_G_REL : S_G_STROBE;
            S_G_REL:    state_nxt_s = S_R_WAIT;
            S_R_WAIT: begin
                if (bus.my_turn) begin
                    state_nxt_s = bus.match_found ? S_P_CAP : S_DONE;
                end else begin
                    state_nxt_s = S_R_WAIT;
                end
            end
            S_P_CAP:    state_nxt_s = bus.my_turn ? S_P_STROBE : S_P_CAP;
            S_P_STROBE: state_nxt_s = strobe_last_s ? S_P_REL : S_P_STROBE;
            S_P_REL:    state_nxt_s = (pw_idx_q == PI_W'(PASSWORD_BYTES - 1)) ? S_EMIT : S_P_CAP;
            S_EMIT:     state_nxt_s = (pw_valid_q && bus.pw_ready) ? S_R_WAIT : S_EMIT;
            S_DONE:     state_nxt_s = S_DONE;
            default:    state_nxt_s = S_IDLE;
        endcase
        state_d = timeout_s ? S_DONE : state_nxt_s;
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        pw_idx_d     = pw_idx_q;
        loaded_d     = loaded_q;
        pw_sr_d      = pw_sr_q;
        nhb_d        = nhb_q;
        strobe_cnt_d = (is_strobe_s && (state_d == state_q)) ? strobe_cnt_q + SC_W'(1) : SC_W'(0);
        case (state_q)
            S_IDLE: begin
                word_d     = (state_d == S_B_WAIT) ? bus.hash_in_data : word_q;
                byte_idx_d = (state_d == S_B_WAIT) ? BI_W'(0) : byte_idx_q;
            end
            S_B_WAIT: nhb_d = (state_d == S_B_SETUP) ? word_q[8*byte_idx_q +: 8] : nhb_q;
            S_B_REL: begin
                loaded_d   = (state_d == S_IDLE) ? loaded_q + 8'd1 : loaded_q;
                byte_idx_d = (state_d == S_B_WAIT) ? byte_idx_q + BI_W'(1) : byte_idx_q;
            end
            S_R_WAIT: pw_idx_d = (state_d == S_P_CAP) ? PI_W'(0) : pw_idx_q;
            // First byte captured ends up in the top byte after the last shift.
            S_P_CAP:  pw_sr_d  = (state_d == S_P_STROBE) ?
                                 ((pw_sr_q << 4'd8) | PW_W'(bus.password_byte)) : pw_sr_q;
            S_P_REL:  pw_idx_d = (state_d == S_P_CAP) ? pw_idx_q + PI_W'(1) : pw_idx_q;
            default: begin
                word_d = word_q;
            end
        endcase
        store_d     = (state_d == S_B_STROBE);
        go_d        = (state_d == S_G_STROBE) || (state_d == S_P_STROBE);
        pw_valid_d  = (state_d == S_EMIT);
        hin_ready_d = (state_d == S_IDLE) && (loaded_d < 8'(NUM_HASHES));
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_q       <= HW_W'(0);
            byte_idx_q   <= BI_W'(0);
            pw_idx_q     <= PI_W'(0);
            strobe_cnt_q <= SC_W'(0);
            loaded_q     <= 8'd0;
            pw_sr_q      <= PW_W'(0);
            nhb_q        <= 8'd0;
            store_q      <= 1'b0;
            go_q         <= 1'b0;
            pw_valid_q   <= 1'b0;
            hin_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            pw_idx_q     <= pw_idx_d;
            strobe_cnt_q <= strobe_cnt_d;
            loaded_q     <= loaded_d;
            pw_sr_q      <= pw_sr_d;
            nhb_q        <= nhb_d;
            store_q      <= store_d;
            go_q         <= go_d;
            pw_valid_q   <= pw_valid_d;
            hin_ready_q  <= hin_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.hash_in_ready   = hin_ready_q;
    assign bus.new_hash_byte   = nhb_q;
    assign bus.store_hash_byte = store_q;
    assign bus.go              = go_q;
    assign bus.pw_data         = pw_sr_q;
    assign bus.pw_valid        = pw_valid_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign hashes_loaded_o     = loaded_q;
endmodule

// File: doc/ntcrack_host_sequencer.md
Name: ntcrack_host_sequencer

Overview:
- Hardware host-side driver for the ntcrackfpga byte-serial cracker interface.
- Loads NUM_HASHES target hashes, starts the search, reads back each recovered password byte by byte, and presents it as one wide word with a valid/ready handshake.
- Sits between an on-chip controller (UART bridge or soft CPU) and the cracker core.
- Generalises the byte protocol in hash count, hash width, password length and strobe width.

Parameters:
NUM_HASHES, 2, number of hashes loaded before start is accepted (1..255)
HASH_BYTES, 16, bytes per hash
PASSWORD_BYTES, 20, bytes per recovered password
STROBE_CYCLES, 2, cycles store_hash_byte or go is held high (>=1)
TIMEOUT_CYCLES, 1048576, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hash_in_data  in  8*HASH_BYTES  hash word; byte 0 = bits [7:0], sent first
hash_in_valid  in  1  hash word offered
hash_in_ready  out  1  hash word accepted when valid&&ready
start  in  1  begin search (single-cycle pulse)
new_hash_byte  out  8  byte to cracker
store_hash_byte  out  1  cracker store strobe
go  out  1  cracker go/advance strobe
match_found  in  1  cracker result flag, sampled only when my_turn=1
my_turn  in  1  cracker ready for host action
password_byte  in  8  cracker password byte
pw_data  out  8*PASSWORD_BYTES  recovered password; first byte read = MSB byte
pw_valid  out  1  pw_data valid
pw_ready  in  1  consumer accepts pw_data
busy  out  1  high in any state except IDLE and DONE
done  out  1  sticky: search exhausted
error  out  1  sticky: watchdog expired
hashes_loaded  out  8  count of hashes fully sent

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; counters cleared. The cracker is not reset by this block; the system resets both together. Reset mid-operation aborts immediately and drops strobes on the next edge.
- IDLE: hash_in_ready=1 iff hashes_loaded<NUM_HASHES. On handshake, latch the word, set byte_idx=0 and go to B_WAIT. start is accepted only when hashes_loaded==NUM_HASHES; it then goes to G_WAIT. start is ignored in every other case and in every other state.
- B_WAIT: wait for my_turn=1, then go to B_SETUP.
- B_SETUP: drive new_hash_byte=word[8*byte_idx+:8] (held until the next byte), then go to B_STROBE.
- B_STROBE: store_hash_byte=1 for STROBE_CYCLES cycles, then go to B_REL.
- B_REL: store_hash_byte=0 for 1 cycle. If byte_idx==HASH_BYTES-1, increment hashes_loaded and go to IDLE; otherwise increment byte_idx and go to B_WAIT.
- G_WAIT: wait for my_turn, then go to G_STROBE.
- G_STROBE: go=1 for STROBE_CYCLES cycles.
- G_REL: go=0 for 1 cycle, then go to R_WAIT.
- R_WAIT: on my_turn=1:
  - match_found=1: clear pw_idx and go to P_CAP.
  - match_found=0: go to DONE.
- P_CAP: on my_turn=1, shift password_byte into pw shift register (MSB first) and go to P_STROBE.
- P_STROBE: go=1 for STROBE_CYCLES cycles.
- P_REL: go=0 for 1 cycle. If pw_idx==PASSWORD_BYTES-1, go to EMIT; otherwise increment pw_idx and go to P_CAP.
- EMIT: pw_valid=1, pw_data stable. Hold until pw_ready=1 (stall indefinitely); on handshake drop pw_valid next cycle and go to R_WAIT.
- DONE: done=1. Stays in DONE until reset.
- Strobe counter is width clog2(STROBE_CYCLES+1). With STROBE_CYCLES=1, each strobe is exactly one cycle.
- Simultaneous hash_in_valid and start in IDLE with count==NUM_HASHES: start wins, hash_in_ready is already 0.
- pw_data is held after the handshake until the next capture begins. The first captured byte lands in bits [8*PASSWORD_BYTES-1 -: 8].

Optional Feature:
NTCRACK_HOST_TIMEOUT_EN
- Defined: a watchdog counter runs in every *_WAIT and P_CAP state and is cleared on each state change. On reaching TIMEOUT_CYCLES:
  - error=1 (sticky), strobes drop, state goes to DONE, done=1.
- Undefined: no counter is built, error is tied to 0, and waits are unbounded.

Test Plan:
- Load 588FEB889288FB953B5F094D47D1565C then 91D533DC611AC2774431E2D0BAF36805, with a cracker model whose my_turn is always 1 -> byte sequence on new_hash_byte is 5C,56,D1,47,...,58 then 05,68,F3,...,91. Each store_hash_byte pulse is exactly 2 cycles. hashes_loaded ends at 2 and hash_in_ready drops.
- start pulsed with hashes_loaded=1 -> ignored: busy stays 0 and go stays 0. start after the 2nd load -> single 2-cycle go pulse, busy=1.
- Model returns match_found=1 with bytes 31,00,32,00 then 16×00 -> pw_valid=1 with pw_data=0x31003200 followed by 128 zero bits, and exactly 20 go pulses during readout. Hold pw_ready=0 for 10 cycles -> pw_valid and pw_data stable throughout.
- After one emit, model reports match_found=0 -> done=1, busy=0, and no further strobes for 100 cycles.
- Assert reset during the 2nd cycle of B_STROBE -> store_hash_byte=0 on the next edge, all outputs 0, hashes_loaded=0.
- With NTCRACK_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=64, hold my_turn=0 after start -> error=1 and done=1 exactly 64 cycles after entering G_WAIT. Without the macro -> error stays 0.
